soft_mute_gain: RTL and testbench
=================================

Name: soft_mute_gain

Overview:
Gain and soft-mute stage between the 20-bit sample source (sine generator, later audio input) and the interpolating filter, all on the 128x44.1 kHz system clock.
- Scales each incoming sample by a programmable gain.
- Applies a linear click-free ramp on mute and unmute, and soft-starts from reset.
- Converts 20-bit to 16-bit with saturation, and flags clipping per sample.

Parameters:
RAMP_LOG2, 8, ramp length in samples = 2^RAMP_LOG2 (256 samples, about 5.8 ms at 44.1 kHz); legal range 1..12.

Ports:
clk  input  1  system clock (128x44.1 kHz domain)
reset  input  1  asynchronous, active-high reset
sample_en  input  1  one-cycle strobe: sample_in valid this cycle (may be asserted on back-to-back cycles)
sample_in  input  20  signed two's-complement input sample
gain  input  8  unsigned Q1.7 gain (0x80 = 1.0, 0xFF = 1.9921875)
mute  input  1  level: 1 = ramp to silence, 0 = ramp to full gain
sample_out  output  16  signed scaled/saturated sample, held between updates
sample_valid  output  1  one-cycle strobe: sample_out updated this cycle
clip  output  1  valid with sample_valid: 1 if this sample saturated
muted  output  1  1 while state is MUTED

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: sample_out=0, sample_valid=0, clip=0, muted=1, state=MUTED, ramp_cnt=0, all pipeline registers 0. Reset may assert at any time, including mid-ramp or mid-pipeline. An in-flight sample is discarded with no sample_valid.
- ramp_cnt: RAMP_LOG2+1 bits, range 0..FULL, where FULL = 2^RAMP_LOG2.
- States: MUTED (cnt=0), RAMP_UP, UNMUTED (cnt=FULL), RAMP_DOWN.
- All state, ramp_cnt, gain and mute sampling happens only on cycles with sample_en=1. Nothing changes otherwise.
- On each sample_en, first compute the effective gain from the current (pre-update) ramp_cnt: eff_gain = (gain * ramp_cnt) >> RAMP_LOG2, 8-bit unsigned, truncating. Then update ramp_cnt and state:
  - MUTED: mute=0 -> cnt=1, RAMP_UP; else stay.
  - RAMP_UP: mute=1 -> cnt-1, RAMP_DOWN (MUTED if the result is 0). mute=0 -> cnt+1, UNMUTED if the result = FULL.
  - UNMUTED: mute=1 -> cnt-1, RAMP_DOWN; else stay.
  - RAMP_DOWN: mute=0 -> cnt+1, RAMP_UP (UNMUTED if the result = FULL). mute=1 -> cnt-1, MUTED if the result = 0.
- muted is registered from the next state. It deasserts on the same edge that leaves MUTED.
- Pipeline:
  - Stage 1, on the sample_en edge: register sample_in and eff_gain.
  - Stage 2: p = s1_sample * {0,s1_eff_gain} (29-bit signed), then r = p >>> 11 (arithmetic, floor).
  - Saturate r to [-32768, 32767]. Register sample_out, set clip = (r was out of range), assert sample_valid.
- Latency: sample_valid asserts exactly 2 clk cycles after the sample_en cycle.
- Throughput: one sample per clk; consecutive sample_en produce consecutive sample_valid.
- gain changes between strobes have no effect until the next sample_en. A gain change never affects a sample already in stage 1.

Test Plan:
1. RAMP_LOG2=2, reset then release; mute=0, gain=0x80, sample_in=262144, five strobes -> sample_out = 0, 4096, 8192, 12288, 16384. muted falls at the 1st strobe edge; state UNMUTED after the 4th strobe.
2. Full ramp, gain=0xFF; sample_in=524287 -> sample_out=32767, clip=1. sample_in=-524288 -> sample_out=-32768, clip=1. sample_in=1000, gain=0x80 -> 62, clip=0.
3. RAMP_LOG2=2, two unmuted strobes (cnt=2), then mute=1 -> next strobes give eff_gain 64, 32 (sample_in=262144 -> 8192, 4096). muted=1 after the 2nd of these. A 3rd strobe outputs 0.
4. sample_en on cycles t and t+1 -> sample_valid on t+2 and t+3 with matching data. No strobe for 50 cycles -> sample_out held, sample_valid=0.
5. Floor rounding and gain latching: full ramp, gain=0x80, sample_in=-1 -> sample_out=-1. Change gain to 0x40 mid-gap -> the next output reflects 0x40 only on the following strobe.
6. Assert reset asynchronously mid-RAMP_UP with a sample in flight -> outputs 0 immediately, no sample_valid, muted=1. After release with mute=0, the ramp restarts from eff_gain 0.

Source files
------------

// File: rtl/soft_mute_gain.sv
// Gain and soft-mute stage: scales 20-bit samples by a Q1.7 gain, applies a
// linear mute/unmute ramp of 2^RAMP_LOG2 samples, and saturates to 16 bits.
//
// Handshake: sample_en is a one-cycle input strobe with no back-pressure;
// sample_in/gain/mute are sampled only on cycles where it is high. Exactly
// two cycles later sample_valid pulses for one cycle together with
// sample_out and clip. sample_out holds its value between pulses.
module soft_mute_gain #(
  parameter int RAMP_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [19:0] sample_in,
  input  logic [7:0]  gain,
  input  logic        mute,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        clip,
  output logic        muted,
  output logic [1:0]  state_dbg_o
);

  localparam int CW = RAMP_LOG2 + 1;
  localparam logic [CW-1:0] FULL = {1'b1, {RAMP_LOG2{1'b0}}};
  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [CW-1:0] ONE  = {{RAMP_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    UNMUTED   = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      ramp_cnt_q;
  logic               muted_q;

  logic               s1_valid_q;
  logic signed [19:0] s1_sample_q;
  logic [7:0]         s1_gain_q;

  logic [15:0]        sample_out_q;
  logic               sample_valid_q;
  logic               clip_q;

  // Effective gain uses the ramp count before this strobe's update.
  logic [CW+7:0]      gain_prod;
  logic [7:0]         eff_gain;
  logic [CW-1:0]      cnt_up;
  logic [CW-1:0]      cnt_dn;

  assign gain_prod = gain * ramp_cnt_q;
  assign eff_gain  = gain_prod[RAMP_LOG2 +: 8];
  assign cnt_up    = ramp_cnt_q + ONE;
  assign cnt_dn    = ramp_cnt_q - ONE;

  // Mute ramp FSM: advances one step per accepted sample, muted is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= MUTED;
      ramp_cnt_q <= ZERO;
      muted_q    <= 1'b1;
    end else if (sample_en) begin
      case (state_q)
        MUTED: begin
          if (!mute) begin
            ramp_cnt_q <= ONE;
            state_q    <= RAMP_UP;
            muted_q    <= 1'b0;
          end
        end
        RAMP_UP, UNMUTED, RAMP_DOWN: begin
          if (mute) begin
            if (state_q != MUTED) begin
              ramp_cnt_q <= cnt_dn;
              state_q    <= (cnt_dn == ZERO) ? MUTED : RAMP_DOWN;
              muted_q    <= (cnt_dn == ZERO);
            end
          end else if (state_q != UNMUTED) begin
            ramp_cnt_q <= cnt_up;
            state_q    <= (cnt_up == FULL) ? UNMUTED : RAMP_UP;
            muted_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= MUTED;
          ramp_cnt_q <= ZERO;
          muted_q    <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1: capture the sample together with the gain that applies to it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_gain_q   <= '0;
    end else begin
      s1_valid_q <= sample_en;
      if (sample_en) begin
        s1_sample_q <= signed'(sample_in);
        s1_gain_q   <= eff_gain;
      end
    end
  end

  // Stage 2 arithmetic: signed multiply, floor shift by 11, saturate to 16 bits.
  logic signed [28:0] prod;
  logic signed [17:0] scaled;
  logic [15:0]        sat_val;
  logic               sat_clip;

  always_comb begin
    prod     = s1_sample_q * signed'({1'b0, s1_gain_q});
    scaled   = prod[28:11];
    sat_val  = scaled[15:0];
    sat_clip = 1'b0;
    if (scaled > 18'sd32767) begin
      sat_val  = 16'h7FFF;
      sat_clip = 1'b1;
    end else if (scaled < -18'sd32768) begin
      sat_val  = 16'h8000;
      sat_clip = 1'b1;
    end
  end

  // Output register: data and clip update only with a valid stage-1 sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      clip_q         <= 1'b0;
    end else begin
      sample_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sample_out_q <= sat_val;
        clip_q       <= sat_clip;
      end
    end
  end

  // Low product bits and the top gain product bit are dropped by design.
  logic unused_bits;
  assign unused_bits = ^{prod[10:0], gain_prod[RAMP_LOG2-1:0], gain_prod[CW+7]};

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign clip         = clip_q;
  assign muted        = muted_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_soft_mute_gain.sv
// Bench for soft_mute_gain with a 4-sample ramp.
module tb_soft_mute_gain;

  logic        clk;
  logic        reset;
  logic        sample_en;
  logic [19:0] sample_in;
  logic [7:0]  gain;
  logic        mute;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        clip;
  logic        muted;
  logic [1:0]  state_dbg_o;

  int total = 0;
  int bad   = 0;

  // Expected {clip, sample_out} per accepted sample.
  logic [16:0] exp_q[$];

  soft_mute_gain #(.RAMP_LOG2(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_en    (sample_en),
    .sample_in    (sample_in),
    .gain         (gain),
    .mute         (mute),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .clip         (clip),
    .muted        (muted),
    .state_dbg_o  (state_dbg_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Scoreboard: compare every output pulse against the queued expectation.
  always @(negedge clk) begin
    if (sample_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got out=%h clip=%b, expected no output", sample_out, clip);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({clip, sample_out} !== e) begin
          bad++;
          $display("FAIL sample: got out=%h clip=%b, expected out=%h clip=%b",
                   sample_out, clip, e[15:0], e[16]);
        end
      end
    end
  end

  // Driver tasks: called at 1 time unit after a rising edge.
  task automatic send(input logic [19:0] s, input logic [15:0] d, input logic c);
    sample_en = 1'b1;
    sample_in = s;
    exp_q.push_back({c, d});
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d outputs pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++;
    if ({sample_out, sample_valid, clip, muted, state_dbg_o} !== {16'h0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL reset_values: got out=%h v=%b clip=%b muted=%b st=%0d, expected 0 0 0 1 0",
               sample_out, sample_valid, clip, muted, state_dbg_o);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Soft start from mute with 262144 at unity gain.
  task automatic test_ramp_up();
    mute = 1'b0;
    gain = 8'h80;
    send(20'd262144, 16'd0, 1'b0);
    check_bit("muted_after_first_strobe", muted, 1'b0);
    send(20'd262144, 16'd4096, 1'b0);
    send(20'd262144, 16'd8192, 1'b0);
    send(20'd262144, 16'd12288, 1'b0);
    total++;
    if (state_dbg_o !== 2'd2) begin
      bad++;
      $display("FAIL state_after_ramp: got %0d, expected 2", state_dbg_o);
    end
    send(20'd262144, 16'd16384, 1'b0);
    wait_drain();
  endtask

  task automatic test_saturation();
    gain = 8'hFF;
    send(20'h7FFFF, 16'h7FFF, 1'b1);
    send(20'h80000, 16'h8000, 1'b1);
    gain = 8'h80;
    send(20'd1000, 16'd62, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] held;
    gain = 8'h80;
    send(20'd262144, 16'd16384, 1'b0);
    send(-20'sd262144, 16'hC000, 1'b0);
    check_bit("latency_first", sample_valid, 1'b1);
    idle(1);
    check_bit("latency_second", sample_valid, 1'b1);
    idle(1);
    held = 16'hC000;
    for (int i = 0; i < 50; i++) begin
      total++;
      if (sample_valid !== 1'b0 || sample_out !== held) begin
        bad++;
        $display("FAIL idle_hold: got v=%b out=%h, expected v=0 out=%h", sample_valid, sample_out, held);
      end
      idle(1);
    end
    wait_drain();
  endtask

  task automatic test_floor_and_latch();
    gain = 8'h80;
    send(20'hFFFFF, 16'hFFFF, 1'b0);
    send(20'd262144, 16'd16384, 1'b0);
    gain = 8'h40;
    wait_drain();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (sample_out !== 16'd16384) begin
        bad++;
        $display("FAIL gain_latch_hold: got %h, expected %h", sample_out, 16'd16384);
      end
      idle(1);
    end
    send(20'd262144, 16'd8192, 1'b0);
    wait_drain();
  endtask

  task automatic test_ramp_down();
    pulse_reset();
    mute = 1'b0;
    gain = 8'h80;
    send(20'd262144, 16'd0, 1'b0);
    send(20'd262144, 16'd4096, 1'b0);
    mute = 1'b1;
    send(20'd262144, 16'd8192, 1'b0);
    check_bit("muted_mid_rampdown", muted, 1'b0);
    total++;
    if (state_dbg_o !== 2'd3) begin
      bad++;
      $display("FAIL state_rampdown: got %0d, expected 3", state_dbg_o);
    end
    send(20'd262144, 16'd4096, 1'b0);
    check_bit("muted_after_rampdown", muted, 1'b1);
    send(20'd262144, 16'd0, 1'b0);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    mute = 1'b0;
    gain = 8'h80;
    send(20'd262144, 16'd0, 1'b0);
    wait_drain();
    send(20'd262144, 16'd4096, 1'b0);
    wait_drain();
    send(20'd262144, 16'd8192, 1'b0);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    total++;
    if ({sample_out, sample_valid, clip, muted, state_dbg_o} !== {16'h0, 1'b0, 1'b0, 1'b1, 2'd0}) begin
      bad++;
      $display("FAIL async_reset: got out=%h v=%b clip=%b muted=%b st=%0d, expected 0 0 0 1 0",
               sample_out, sample_valid, clip, muted, state_dbg_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_bit("valid_in_reset", sample_valid, 1'b0);
    end
    reset = 1'b0;
    idle(2);
    check_bit("no_stale_valid", sample_valid, 1'b0);
    send(20'd262144, 16'd0, 1'b0);
    send(20'd262144, 16'd4096, 1'b0);
    wait_drain();
  endtask

  initial begin
    reset     = 1'b1;
    sample_en = 1'b0;
    sample_in = '0;
    gain      = 8'h80;
    mute      = 1'b1;
    test_reset();
    test_ramp_up();
    test_saturation();
    test_back_to_back();
    test_floor_and_latch();
    test_ramp_down();
    test_reset_mid();
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
